ex_mult3_unit: RTL
==================

Name: ex_mult3_unit

Overview:
- Multi-cycle integer multiplier in the EX stage, directly downstream of the forwarding unit.
- Consumes that unit's Forward_A/Forward_B selects and the three operand sources, and muxes the operands itself.
- Captures the operands once, produces an RV64M MUL/MULH/MULHSU/MULHU result three cycles later, and raises a stall to the hazard unit while busy.

Parameters:
- DATA_W, 64, operand/result width (even, >=8)

Ports:
- clk  in  1  system clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- mul_start  in  1  ID/EX holds a valid M-extension multiply (held high while stalled)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; others reserved
- flush  in  1  kill in-flight multiply (branch/exception redirect)
- forward_a  in  2  00 regfile, 10 EX/MEM, 01 MEM/WB; 11 treated as 00
- forward_b  in  2  same encoding; B never selects the immediate
- rs1_data  in  DATA_W  ID/EX register-file rs1
- rs2_data  in  DATA_W  ID/EX register-file rs2
- ex_mem_alu_out  in  DATA_W  EX/MEM forwarded value
- mem_wb_wdata  in  DATA_W  MEM/WB write-back value
- mul_stall  out  1  freeze PC, IF/ID, ID/EX; bubble EX/MEM
- mul_valid  out  1  mul_result valid this cycle, latched into EX/MEM
- mul_result  out  DATA_W  selected product half

Behaviour:
- Reset (arst_n low, asynchronous): state=IDLE; all internal operand/partial/funct3 registers cleared; mul_stall=0, mul_valid=0, mul_result=0.

Operand mux (combinational, used only at capture):
- op = 10 → ex_mem_alu_out; 01 → mem_wb_wdata; else → rsX_data.

FSM states: IDLE, M1, M2, DONE.
- IDLE & mul_start & !flush: capture muxed A, B and funct3 into registers; go to M1. Capture happens only here, because forwarding sources change while the pipeline is stalled.
- M1: extend operands to DATA_W+1 bits. A is signed for 001/010; B is signed for 001 only; otherwise zero-extended. Register the four half-width cross partial products. → M2.
- M2: sum the partial products into a registered 2*DATA_W+2-bit product. → DONE.
- DONE: mul_valid=1. mul_result = product[DATA_W-1:0] for 000, else product[2*DATA_W-1:DATA_W]. → IDLE unconditionally, even if mul_start is still high, so the held instruction never re-issues.
- Latency: capture at edge 0, mul_valid high in cycle 3; 3 stall cycles per multiply.

mul_stall (combinational):
- (IDLE & mul_start & !flush) | M1 | M2.
- Low in DONE, so the pipeline advances on the DONE edge.

mul_valid:
- Registered; 1 only in DONE.
- mul_result holds its last value otherwise, and is 0 after reset.

Back-to-back multiplies:
- A new mul_start seen in IDLE the cycle after DONE starts a fresh operation. Throughput is 1 per 4 cycles.

Flush:
- Any state → IDLE next edge.
- mul_stall forced 0 in the same cycle.
- mul_valid not asserted for the killed operation, even if flush arrives in M2.
- flush in DONE: mul_valid still 1 this cycle; the consumer discards it.

Reserved funct3:
- Treated as 000 (low product).

Reset mid-operation:
- Immediate IDLE; outputs 0; no spurious mul_valid after release.

Arithmetic:
- Exact two's-complement product; no saturation.
- MULHSU treats B as unsigned.

Test Plan:
1. Basic MUL: rs1=7, rs2=6, fwd 00/00, start at cycle 0 → mul_stall=1 cycles 0-2, mul_valid=1 cycle 3, mul_result=42; cycle 4 IDLE, no re-issue though mul_start still high through cycle 3.
2. Forwarding capture: fwd_a=10, ex_mem_alu_out=0x10; fwd_b=01, mem_wb_wdata=3; rs1=rs2=0. ex_mem/mem_wb change to 0xFFFF from cycle 1 → result 0x30 (operands taken at capture only).
3. High halves (DATA_W=64): A=0xFFFF_FFFF_FFFF_FFFF (−1), B=2. MULH → 0xFFFF_FFFF_FFFF_FFFF; MULHU → 0x1; MULHSU → 0xFFFF_FFFF_FFFF_FFFF; MUL → 0xFFFF_FFFF_FFFF_FFFE.
4. Flush in M2: start MUL 5×5, assert flush cycle 2 → mul_stall 0 in cycle 2, mul_valid never 1, state IDLE cycle 3.
5. Back-to-back: two MULs (3×4, then 9×9) with mul_start continuous → results 12 at cycle 3 and 81 at cycle 7; mul_stall low only in cycles 3 and 7.
6. Async reset: arst_n low mid-M1 (not clock-aligned) → outputs 0 immediately; after release with mul_start=0, no mul_valid for 10 cycles.

Source files
------------

// File: rtl/ex_mult3_unit.sv
// EX-stage multi-cycle RV64M multiplier: captures forwarded operands once and returns
// MUL/MULH/MULHSU/MULHU three cycles later, stalling the pipeline while busy.
module ex_mult3_unit #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              mul_start,
    input  logic [2:0]        funct3,
    input  logic              flush,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] ex_mem_alu_out,
    input  logic [DATA_W-1:0] mem_wb_wdata,
    output logic              mul_stall,
    output logic              mul_valid,
    output logic [DATA_W-1:0] mul_result
);

    localparam int H = DATA_W / 2;
    localparam int P = 2 * DATA_W + 2;

    typedef enum logic [1:0] {IDLE, M1, M2, DONE} state_t;

    state_t                   state;
    logic [DATA_W-1:0]        a_q;
    logic [DATA_W-1:0]        b_q;
    logic [2:0]               f3_q;
    logic signed [DATA_W+1:0] pp_hh;
    logic signed [DATA_W+1:0] pp_hl;
    logic signed [DATA_W+1:0] pp_lh;
    logic signed [DATA_W+1:0] pp_ll;
    logic [P-1:0]             product;
    logic [DATA_W-1:0]        result_q;

    logic [DATA_W-1:0]        op_a;
    logic [DATA_W-1:0]        op_b;
    logic                     capture;
    logic                     a_signed;
    logic                     b_signed;
    logic                     sel_hi;
    logic [DATA_W:0]          a_ext;
    logic [DATA_W:0]          b_ext;
    logic signed [DATA_W+1:0] a_hi_x;
    logic signed [DATA_W+1:0] a_lo_x;
    logic signed [DATA_W+1:0] b_hi_x;
    logic signed [DATA_W+1:0] b_lo_x;
    logic [P-1:0]             sum_next;
    logic [DATA_W-1:0]        sel_product;

    always_comb begin
        case (forward_a)
            2'b10:   op_a = ex_mem_alu_out;
            2'b01:   op_a = mem_wb_wdata;
            default: op_a = rs1_data;
        endcase
        case (forward_b)
            2'b10:   op_b = ex_mem_alu_out;
            2'b01:   op_b = mem_wb_wdata;
            default: op_b = rs2_data;
        endcase
    end

    assign capture   = (state == IDLE) && mul_start && !flush;
    assign mul_stall = arst_n && !flush &&
                       ((state == IDLE && mul_start) || state == M1 || state == M2);

    assign a_signed = (f3_q == 3'b001) || (f3_q == 3'b010);
    assign b_signed = (f3_q == 3'b001);
    assign sel_hi   = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b011);

    assign a_ext = {a_signed & a_q[DATA_W-1], a_q};
    assign b_ext = {b_signed & b_q[DATA_W-1], b_q};

    // Each extended operand splits into a signed upper part and a non-negative lower half,
    // so the four cross products sum exactly to the full signed product.
    assign a_hi_x = {{(H+1){a_ext[DATA_W]}}, a_ext[DATA_W:H]};
    assign a_lo_x = {{(H+2){1'b0}}, a_ext[H-1:0]};
    assign b_hi_x = {{(H+1){b_ext[DATA_W]}}, b_ext[DATA_W:H]};
    assign b_lo_x = {{(H+2){1'b0}}, b_ext[H-1:0]};

    assign sum_next = ({{DATA_W{pp_hh[DATA_W+1]}}, pp_hh} << DATA_W)
                    + ({{DATA_W{pp_hl[DATA_W+1]}}, pp_hl} << H)
                    + ({{DATA_W{pp_lh[DATA_W+1]}}, pp_lh} << H)
                    +  {{DATA_W{pp_ll[DATA_W+1]}}, pp_ll};

    assign sel_product = sel_hi ? product[2*DATA_W-1:DATA_W] : product[DATA_W-1:0];
    assign mul_result  = (state == DONE) ? sel_product : result_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            f3_q      <= '0;
            pp_hh     <= '0;
            pp_hl     <= '0;
            pp_lh     <= '0;
            pp_ll     <= '0;
            product   <= '0;
            result_q  <= '0;
            mul_valid <= 1'b0;
        end else begin
            // The result presented in DONE is held afterwards, even when that cycle is flushed.
            if (state == DONE) begin
                result_q <= sel_product;
            end
            if (flush) begin
                state     <= IDLE;
                mul_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        mul_valid <= 1'b0;
                        if (capture) begin
                            a_q   <= op_a;
                            b_q   <= op_b;
                            f3_q  <= funct3;
                            state <= M1;
                        end
                    end
                    M1: begin
                        pp_hh <= a_hi_x * b_hi_x;
                        pp_hl <= a_hi_x * b_lo_x;
                        pp_lh <= a_lo_x * b_hi_x;
                        pp_ll <= a_lo_x * b_lo_x;
                        state <= M2;
                    end
                    M2: begin
                        product   <= sum_next;
                        mul_valid <= 1'b1;
                        state     <= DONE;
                    end
                    default: begin
                        mul_valid <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
